sram_word_arbiter: RTL

- Shares the single 32-bit word port of the external-SRAM controller between the CPU (read/write) and the video scanout engine (read-only).
- Sits between the two requesters and the controller's word_rd/word_wr/word_busy/word_q_valid interface.
- Video has fixed priority; a streak counter bounds CPU starvation.
- One transaction is in flight at a time; each requester gets its own psram-style strobe/busy/q_valid port.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_req_slot.sv | 68 ++++++
 rtl/sram_word_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM word-port arbiter: FSM states, owner IDs, default address width.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 22;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arb_req_slot.sv
// One requester's pending slot: latches a strobe while idle and holds busy until the arbiter retires it.
// Strobes while busy are dropped; rd and wr together are taken as a write.
module sram_arb_req_slot
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        wstrb_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       data_o,
  output logic [3:0]        wstrb_o
);

  logic              busy_q, busy_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        wstrb_q, wstrb_d;

  always_comb begin
    busy_d  = busy_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wstrb_d = wstrb_q;
    if (busy_q) begin
      if (done_i) busy_d = 1'b0;
    end else if (rd_i || wr_i) begin
      busy_d  = 1'b1;
      wr_d    = wr_i;
      addr_d  = addr_i;
      data_d  = data_i;
      wstrb_d = wstrb_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wstrb_q <= '0;
    end else begin
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign busy_o  = busy_q;
  assign wr_o    = wr_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign wstrb_o = wstrb_q;

endmodule

// File: rtl/sram_word_arbiter.sv
// Shares the SRAM controller word port between CPU (rd/wr) and video (rd); video has priority, bounded by a streak counter.
// Defining SRAM_ARB_STATS_EN adds saturating grant counters (stat_cpu_grants, stat_vid_grants, stat_forced).
module sram_word_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_VID_STREAK = 4,
  parameter int ADDR_W         = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_data,
  input  logic [3:0]        cpu_wstrb,
  output logic [31:0]       cpu_q,
  output logic              cpu_busy,
  output logic              cpu_q_valid,
  input  logic              vid_rd,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [31:0]       vid_q,
  output logic              vid_busy,
  output logic              vid_q_valid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_q,
  input  logic              mem_busy,
  input  logic              mem_q_valid
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_grants,
  output logic [31:0]       stat_vid_grants,
  output logic [15:0]       stat_forced
`endif
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_VID_STREAK);

  logic              cpu_busy_s, cpu_wr_s, vid_busy_s, vid_wr_s;
  logic [ADDR_W-1:0] cpu_addr_s, vid_addr_s;
  logic [31:0]       cpu_data_s, vid_data_s;
  logic [3:0]        cpu_wstrb_s, vid_wstrb_s;
  logic              cpu_done, vid_done;

  sram_arb_req_slot #(.ADDR_W(ADDR_W)) u_cpu_slot (
    .clk    (clk),         .reset  (reset),
    .rd_i   (cpu_rd),      .wr_i   (cpu_wr),
    .addr_i (cpu_addr),    .data_i (cpu_data),
    .wstrb_i(cpu_wstrb),   .done_i (cpu_done),
    .busy_o (cpu_busy_s),  .wr_o   (cpu_wr_s),
    .addr_o (cpu_addr_s),  .data_o (cpu_data_s),
    .wstrb_o(cpu_wstrb_s)
  );

  sram_arb_req_slot #(.ADDR_W(ADDR_W)) u_vid_slot (
    .clk    (clk),         .reset  (reset),
    .rd_i   (vid_rd),      .wr_i   (1'b0),
    .addr_i (vid_addr),    .data_i (32'h0),
    .wstrb_i(4'h0),        .done_i (vid_done),
    .busy_o (vid_busy_s),  .wr_o   (vid_wr_s),
    .addr_o (vid_addr_s),  .data_o (vid_data_s),
    .wstrb_o(vid_wstrb_s)
  );

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       cap_q, cap_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic              cpu_qv_q, cpu_qv_d, vid_qv_q, vid_qv_d;
  logic              cpu_waiting, grant_cpu, forced;
  logic [31:0]       rdata;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wstrb_d     = wstrb_q;
    cap_d       = cap_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_qv_d    = 1'b0;
    vid_qv_d    = 1'b0;
    cpu_done    = 1'b0;
    vid_done    = 1'b0;
    grant_cpu   = 1'b0;
    forced      = 1'b0;
    rdata       = mem_q_valid ? mem_q : cap_q;
    // The CPU slot stays busy while in service; only a not-yet-granted request counts as waiting.
    cpu_waiting = cpu_busy_s && !((state_q != IDLE) && (owner_q == OWN_CPU));
    if (!cpu_waiting) streak_d = '0;
    if (mem_q_valid) cap_d = mem_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_busy_s || vid_busy_s) begin
          forced    = cpu_busy_s && vid_busy_s && (streak_q == STREAK_MAX);
          grant_cpu = cpu_busy_s && (!vid_busy_s || forced);
          if (grant_cpu) begin
            owner_d  = OWN_CPU;
            op_wr_d  = cpu_wr_s;
            addr_d   = cpu_addr_s;
            data_d   = cpu_data_s;
            wstrb_d  = cpu_wstrb_s;
            streak_d = '0;
          end else begin
            owner_d = OWN_VID;
            op_wr_d = vid_wr_s;
            addr_d  = vid_addr_s;
            data_d  = vid_data_s;
            wstrb_d = vid_wstrb_s;
            if (cpu_busy_s && streak_q != 4'hF) streak_d = streak_q + 4'd1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE:    state_d = WAIT_ACK;
      // Controller busy is registered, so it only rises the cycle after the strobe.
      WAIT_ACK: if (mem_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!mem_busy) begin
          state_d = IDLE;
          if (owner_q == OWN_CPU) begin
            cpu_done = 1'b1;
            if (!op_wr_q) begin
              cpu_rdata_d = rdata;
              cpu_qv_d    = 1'b1;
            end
          end else begin
            vid_done = 1'b1;
            if (!op_wr_q) begin
              vid_rdata_d = rdata;
              vid_qv_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      streak_q    <= '0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wstrb_q     <= '0;
      cap_q       <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_qv_q    <= 1'b0;
      vid_qv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wstrb_q     <= wstrb_d;
      cap_q       <= cap_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_qv_q    <= cpu_qv_d;
      vid_qv_q    <= vid_qv_d;
    end
  end

  assign mem_rd      = (state_q == ISSUE) && !op_wr_q;
  assign mem_wr      = (state_q == ISSUE) &&  op_wr_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign mem_wstrb   = wstrb_q;
  assign cpu_q       = cpu_rdata_q;
  assign cpu_q_valid = cpu_qv_q;
  assign cpu_busy    = cpu_busy_s;
  assign vid_q       = vid_rdata_q;
  assign vid_q_valid = vid_qv_q;
  assign vid_busy    = vid_busy_s;

`ifdef SRAM_ARB_STATS_EN
  logic        forced_q, forced_d;
  logic [31:0] stat_cpu_q, stat_cpu_d, stat_vid_q, stat_vid_d;
  logic [15:0] stat_forced_q, stat_forced_d;

  always_comb begin
    forced_d      = forced_q;
    stat_cpu_d    = stat_cpu_q;
    stat_vid_d    = stat_vid_q;
    stat_forced_d = stat_forced_q;
    if (state_q == IDLE && (cpu_busy_s || vid_busy_s)) forced_d = forced;
    if (state_q == ISSUE) begin
      if (owner_q == OWN_CPU) begin
        if (stat_cpu_q != '1) stat_cpu_d = stat_cpu_q + 32'd1;
        if (forced_q && stat_forced_q != '1) stat_forced_d = stat_forced_q + 16'd1;
      end else if (stat_vid_q != '1) begin
        stat_vid_d = stat_vid_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      forced_q      <= 1'b0;
      stat_cpu_q    <= '0;
      stat_vid_q    <= '0;
      stat_forced_q <= '0;
    end else begin
      forced_q      <= forced_d;
      stat_cpu_q    <= stat_cpu_d;
      stat_vid_q    <= stat_vid_d;
      stat_forced_q <= stat_forced_d;
    end
  end

  assign stat_cpu_grants = stat_cpu_q;
  assign stat_vid_grants = stat_vid_q;
  assign stat_forced     = stat_forced_q;
`endif

endmodule
